spi_frame_master: RTL and testbench

- Initiator end of the team's serial peripheral link. Generates SCLK and chip-select, and shifts a W-bit word out MSB-first on MOSI.
- Simultaneously captures W bits from MISO into rx_data.
- Drives the peripheral-clock and serial-data inputs of the peripheral-side shift register and input conditioners, replacing the button and switch stimulus with a clean, timed frame.
- Mode 0 timing: SCLK idles low, data changes on the falling edge, data is sampled on the rising edge.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_phase_timer.sv | 49 ++++
 rtl/spi_frame_master.sv | 164 ++++++++++++++++
 tb/tb_spi_frame_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the serial peripheral link initiator: frame FSM
// states, default sizing constants and the counter width helper.
package spi_pkg;

    localparam int W_DEFAULT           = 8;
    localparam int HALF_PERIOD_DEFAULT = 4;

    // Frame sequencer states. LEAD/HIGH/LOW/TRAIL each last one SCLK
    // half-period; FINISH is a single-cycle completion strobe.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        HIGH   = 3'd2,
        LOW    = 3'd3,
        TRAIL  = 3'd4,
        FINISH = 3'd5
    } spi_state_t;

    // Width that holds both the bit index (0..w-1) and the phase index
    // (0..hp-1). Never narrower than one bit.
    function automatic int cnt_width(input int w, input int hp);
        int m;
        m = 2;
        if (w > m) begin
            m = w;
        end else begin
            m = m;
        end
        if (hp > m) begin
            m = hp;
        end else begin
            m = m;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period down-counter. A load restarts the count at HALF_PERIOD-1;
// expire is high during the last cycle of the half-period (count at zero).
// Both the count and the expire flag are registers, so expire is glitch-free.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
    parameter int CW          = cnt_width(2, HALF_PERIOD)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] ZERO   = CW'(0);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          expire_r;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = RELOAD;
        end else if (count_r != ZERO) begin
            count_next_s = count_r - ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and its registered zero flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= ZERO;
            expire_r <= 1'b1;
        end else begin
            count_r  <= count_next_s;
            expire_r <= (count_next_s == ZERO);
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/spi_frame_master.sv
// Mode-0 serial link initiator. Sends a W-bit word MSB-first on mosi while
// capturing W bits from miso, framed by an active-low chip select. Every
// output is a register so the peripheral sees clean, glitch-free edges.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] tx_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rx_data,
    output logic         sclk,
    output logic         cs_n,
    output logic         mosi,
    input  logic         miso
);

    localparam int            CW       = cnt_width(W, HALF_PERIOD);
    localparam logic [CW-1:0] BIT_ZERO = CW'(0);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);

    spi_state_t     state_r;
    logic [W-1:0]   shift_r;
    logic           miso_bit_r;
    logic [CW-1:0]  bit_cnt_r;
    logic           sclk_r;
    logic           cs_n_r;
    logic           mosi_r;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   rx_data_r;
    logic           load_s;
    logic           expire_s;

    // Restart the half-period timer whenever a timed state is entered.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            IDLE:    load_s = start;
            LEAD:    load_s = expire_s;
            HIGH:    load_s = expire_s;
            LOW:     load_s = expire_s;
            TRAIL:   load_s = 1'b0;
            FINISH:  load_s = 1'b0;
            default: load_s = 1'b0;
        endcase
    end

    spi_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CW          (CW)
    ) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_s),
        .expire (expire_s)
    );

    // Frame sequencer with shift register, bit counter and registered pins.
    // The miso sample taken on each rising sclk edge is parked in miso_bit_r
    // and enters the shift register on the following shift, so the transmit
    // bits still waiting in the low end are never overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= {W{1'b0}};
            miso_bit_r <= 1'b0;
            bit_cnt_r  <= BIT_ZERO;
            sclk_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rx_data_r  <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        shift_r   <= tx_data;
                        mosi_r    <= tx_data[W-1];
                        bit_cnt_r <= BIT_ZERO;
                        cs_n_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= LEAD;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LEAD: begin
                    if (expire_s) begin
                        sclk_r     <= 1'b1;
                        miso_bit_r <= miso;
                        state_r    <= HIGH;
                    end else begin
                        state_r    <= LEAD;
                    end
                end
                HIGH: begin
                    if (expire_s) begin
                        sclk_r <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r   <= TRAIL;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            shift_r   <= {shift_r[W-2:0], miso_bit_r};
                            mosi_r    <= shift_r[W-2];
                            state_r   <= LOW;
                        end
                    end else begin
                        state_r <= HIGH;
                    end
                end
                LOW: begin
                    if (expire_s) begin
                        sclk_r     <= 1'b1;
                        miso_bit_r <= miso;
                        state_r    <= HIGH;
                    end else begin
                        state_r    <= LOW;
                    end
                end
                TRAIL: begin
                    if (expire_s) begin
                        cs_n_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        mosi_r    <= 1'b0;
                        rx_data_r <= {shift_r[W-2:0], miso_bit_r};
                        state_r   <= FINISH;
                    end else begin
                        state_r   <= TRAIL;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    sclk_r  <= 1'b0;
                    cs_n_r  <= 1'b1;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign sclk    = sclk_r;
    assign cs_n    = cs_n_r;
    assign mosi    = mosi_r;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: two instances (HALF_PERIOD 2 and 1),
// a peripheral shift-register model on miso, and a scoreboard of expected
// frames pushed at acceptance and popped at done.
module tb_spi_frame_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, loop_mode, sel;
    logic [7:0] tx_data;
    logic [7:0] periph_tx, periph_rx, periph_pre;

    logic       start_a, busy_a, done_a, sclk_a, cs_n_a, mosi_a, miso_a;
    logic [7:0] rx_a;
    logic       start_b, busy_b, done_b, sclk_b, cs_n_b, mosi_b, miso_b;
    logic [7:0] rx_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign miso_a  = loop_mode ? mosi_a : periph_tx[7];
    assign miso_b  = loop_mode ? mosi_b : periph_tx[7];

    spi_frame_master #(.W(8), .HALF_PERIOD(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_frame_master #(.W(8), .HALF_PERIOD(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    logic       m_sclk, m_cs_n, m_mosi, m_busy, m_done;
    logic [7:0] m_rx;
    assign m_sclk = sel ? sclk_b : sclk_a;
    assign m_cs_n = sel ? cs_n_b : cs_n_a;
    assign m_mosi = sel ? mosi_b : mosi_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_rx   = sel ? rx_b   : rx_a;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         hp;
        logic       loop;
    } exp_t;

    exp_t exp_q[$];

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int cyc = 0, rises = 0, stray_rises = 0, hi_cnt = 0, cs_low = 0;
    int busy_cyc = 0, last_done_cyc = 0, done_cnt = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic prev_sclk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    logic gap_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rises       = 0;
        stray_rises = 0;
        hi_cnt      = 0;
        cs_low      = 0;
        mosi_bits   = 8'h00;
    endtask

    task automatic frame_done();
        exp_t e;
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
            chk("unexpected_done", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk("rx_data",      m_rx,             e.rx);
            chk("mosi_order",   mosi_bits,        e.tx);
            chk("sclk_rises",   rises,            8);
            chk("stray_rises",  stray_rises,      0);
            chk("cs_low_len",   cs_low,           17 * e.hp);
            chk("sclk_hi_len",  hi_cnt,           8 * e.hp);
            chk("done_latency", cyc - busy_cyc,   17 * e.hp);
            if (!e.loop) begin
                chk("periph_rx", periph_rx, e.tx);
            end else begin
                chk("loop_rx_matches_tx", m_rx, e.tx);
            end
        end
        clear_stats();
    endtask

    // One clock step: sample at the falling edge, run the peripheral model
    // and frame monitors, and score completed frames.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (prev_done) chk("done_one_cycle", m_done, 0);
        if (m_sclk && !prev_sclk) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], m_mosi};
            periph_rx = {periph_rx[6:0], m_mosi};
            if (m_cs_n) stray_rises++;
        end
        if (!m_sclk && prev_sclk) periph_tx = {periph_tx[6:0], 1'b0};
        if (m_sclk) hi_cnt++;
        if (!m_cs_n) cs_low++;
        if (m_busy && !prev_busy) begin
            busy_cyc = cyc;
            if (gap_mode) chk("idle_gap", cyc - last_done_cyc, 2);
            e.tx   = tx_data;
            e.rx   = loop_mode ? tx_data : periph_pre;
            e.hp   = sel ? 1 : 2;
            e.loop = loop_mode;
            exp_q.push_back(e);
        end
        if (m_done) frame_done();
        prev_sclk = m_sclk;
        prev_busy = m_busy;
        prev_done = m_done;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic send(input logic [7:0] data);
        tx_data = data;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        int d0;
        reset      = 1'b1;
        start      = 1'b0;
        tx_data    = 8'h00;
        loop_mode  = 1'b1;
        sel        = 1'b0;
        periph_tx  = 8'h00;
        periph_rx  = 8'h00;
        periph_pre = 8'h00;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_sclk", m_sclk, 0);
            chk("idle_cs_n", m_cs_n, 1);
            chk("idle_mosi", m_mosi, 0);
            chk("idle_busy", m_busy, 0);
            chk("idle_done", m_done, 0);
            chk("idle_rx",   m_rx,   8'h00);
        end
        chk("idle_b_cs_n", cs_n_b, 1);

        // Loopback 0xA5
        send(8'hA5);
        wait_done(100);
        tick();

        // Peripheral model preloaded with 0xC3
        loop_mode  = 1'b0;
        periph_pre = 8'hC3;
        periph_tx  = 8'hC3;
        periph_rx  = 8'h00;
        send(8'h3C);
        wait_done(100);
        tick();

        // Reset on the 4th sclk rise of a 0x5A frame
        loop_mode = 1'b1;
        send(8'h5A);
        for (int i = 0; i < 200 && rises < 4; i++) tick();
        chk("abort_rise4_reached", rises, 4);
        reset = 1'b1;
        d0 = done_cnt;
        tick();
        reset = 1'b0;
        chk("abort_cs_n", m_cs_n, 1);
        chk("abort_sclk", m_sclk, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_done", m_done, 0);
        chk("abort_rx",   m_rx,   8'h00);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        clear_stats();
        repeat (40) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        send(8'h96);
        wait_done(100);
        tick();

        // start held high across two frames; tx changes mid-frame
        d0      = done_cnt;
        tx_data = 8'hFF;
        start   = 1'b1;
        repeat (3) tick();
        tx_data  = 8'h00;
        gap_mode = 1'b1;
        wait_done(100);
        for (int i = 0; i < 10 && !m_busy; i++) tick();
        chk("second_frame_busy", m_busy, 1);
        start    = 1'b0;
        gap_mode = 1'b0;
        wait_done(100);
        repeat (5) tick();
        chk("held_start_done_count", done_cnt - d0, 2);

        // HALF_PERIOD = 1 instance, loopback 0x81
        sel = 1'b1;
        tick();
        send(8'h81);
        wait_done(60);
        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
